// File: rtl/pipe_field_gen.sv
// Producer side of the 16x16 game field: game FSM, pipe scrolling/spawning,
// bird motion and score. Every output comes straight from a register.
module pipe_field_gen #(
   parameter int unsigned SCROLL_DIV   = 12_500_000,
   parameter int unsigned FALL_DIV     = 6_250_000,
   parameter int unsigned PIPE_SPACING = 6,
   parameter int unsigned GAP_H        = 4,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              press,
   input  logic              collision,
   output logic [15:0][15:0] red,
   output logic [15:0][15:0] green,
   output logic [7:0]        score,
   output logic              game_over,
   output logic [1:0]        state
);

   localparam int unsigned SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int unsigned FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
   localparam int unsigned PW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;

   typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StOver = 2'd2} state_e;

   state_e              state_q;
   logic [3:0]          bird_row_q;
   logic [15:0][15:0]   red_q, green_q, green_d;
   logic [7:0]          score_q, lfsr_q, lfsr_d;
   logic                game_over_q, press_q;
   logic [SW-1:0]       scroll_cnt_q;
   logic [FW-1:0]       fall_cnt_q;
   logic [PW-1:0]       spawn_q;

   logic                press_rise, scroll_tick, fall_tick, col14_busy;
   logic [4:0]          gap_top;
   logic [15:0]         pipe_col;
   logic [3:0]          bird_next;

   function automatic logic [15:0][15:0] bird_mask(input logic [3:0] row);
      bird_mask = '0;
      bird_mask[row][14] = 1'b1;
   endfunction

   assign press_rise  = press & ~press_q;
   assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign scroll_tick = (scroll_cnt_q == SW'(SCROLL_DIV - 1));
   assign fall_tick   = (fall_cnt_q == FW'(FALL_DIV - 1));

   always_comb begin
      gap_top = {1'b0, lfsr_q[3:0]};
      if (gap_top > 5'(16 - GAP_H)) gap_top = gap_top - 5'(GAP_H);
      pipe_col   = '0;
      col14_busy = 1'b0;
      green_d    = '0;
      for (int r = 0; r < 16; r++) begin
         pipe_col[r] = (5'(r) < gap_top) || (5'(r) >= gap_top + 5'(GAP_H));
         col14_busy  = col14_busy | green_q[r][14];
         // New column enters at bit 0 and everything moves toward column 15.
         green_d[r]  = {green_q[r][14:0], (spawn_q == '0) & pipe_col[r]};
      end
      if (press) bird_next = (bird_row_q == 4'd0) ? 4'd0 : bird_row_q - 4'd1;
      else       bird_next = (bird_row_q == 4'd15) ? 4'd15 : bird_row_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         bird_row_q   <= 4'd7;
         red_q        <= bird_mask(4'd7);
         green_q      <= '0;
         score_q      <= '0;
         game_over_q  <= 1'b0;
         lfsr_q       <= LFSR_SEED;
         press_q      <= 1'b0;
         scroll_cnt_q <= '0;
         fall_cnt_q   <= '0;
         spawn_q      <= '0;
      end else begin
         press_q <= press;
         lfsr_q  <= lfsr_d;
         unique case (state_q)
            StIdle: begin
               if (press_rise) begin
                  state_q      <= StPlay;
                  score_q      <= '0;
                  scroll_cnt_q <= '0;
                  fall_cnt_q   <= '0;
                  spawn_q      <= '0;
               end
            end
            StPlay: begin
               // Collision pre-empts any tick landing in the same cycle.
               if (collision) begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
               end else begin
                  if (scroll_tick) begin
                     scroll_cnt_q <= '0;
                     green_q      <= green_d;
                     spawn_q      <= (spawn_q == '0) ? PW'(PIPE_SPACING - 1) : spawn_q - 1'b1;
                     if (col14_busy && score_q != 8'hFF) score_q <= score_q + 8'd1;
                  end else begin
                     scroll_cnt_q <= scroll_cnt_q + 1'b1;
                  end
                  if (fall_tick) begin
                     fall_cnt_q <= '0;
                     bird_row_q <= bird_next;
                     red_q      <= bird_mask(bird_next);
                  end else begin
                     fall_cnt_q <= fall_cnt_q + 1'b1;
                  end
               end
            end
            StOver: begin
               if (press_rise) begin
                  state_q     <= StIdle;
                  game_over_q <= 1'b0;
                  green_q     <= '0;
                  bird_row_q  <= 4'd7;
                  red_q       <= bird_mask(4'd7);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign red       = red_q;
   assign green     = green_q;
   assign score     = score_q;
   assign game_over = game_over_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pipe_field_gen.sv
// Randomized bench for pipe_field_gen against a column-list game model.
module tb_pipe_field_gen;

   localparam int SCROLL = 4;
   localparam int FALL   = 2;
   localparam int SPACE  = 6;
   localparam int GAPH   = 4;

   logic              clk, rst, press, collision;
   logic [15:0][15:0] red, green;
   logic [7:0]        score;
   logic              game_over;
   logic [1:0]        state;

   pipe_field_gen #(
      .SCROLL_DIV  (SCROLL),
      .FALL_DIV    (FALL),
      .PIPE_SPACING(SPACE),
      .GAP_H       (GAPH),
      .LFSR_SEED   (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .press    (press),
      .collision(collision),
      .red      (red),
      .green    (green),
      .score    (score),
      .game_over(game_over),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a game is a list of columns, each empty (-1) or a pipe with its gap top row.
   int         m_state, m_row, m_score, m_cyc, m_ticks;
   int         m_gap[16];
   logic [7:0] m_lfsr;
   bit         m_press_prev;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] onehot(input int row);
      logic [255:0] v = '0;
      v[row*16 + 14] = 1'b1;
      return v;
   endfunction

   function automatic logic [255:0] exp_green();
      logic [255:0] v = '0;
      for (int c = 0; c < 16; c++)
         if (m_gap[c] >= 0)
            for (int r = 0; r < 16; r++)
               if (r < m_gap[c] || r >= m_gap[c] + GAPH) v[r*16 + c] = 1'b1;
      return v;
   endfunction

   function automatic int gap_of(input logic [7:0] lf);
      int g = int'(lf & 8'h0F);
      return (g <= 16 - GAPH) ? g : g - GAPH;
   endfunction

   task automatic model_reset();
      m_state = 0; m_row = 7; m_score = 0; m_cyc = 0; m_ticks = 0;
      m_lfsr = 8'hA5; m_press_prev = 0;
      for (int c = 0; c < 16; c++) m_gap[c] = -1;
   endtask

   task automatic model_update(input bit p, input bit col);
      bit rise = p && !m_press_prev;
      case (m_state)
         0: if (rise) begin m_state = 1; m_score = 0; m_cyc = 0; m_ticks = 0; end
         1: begin
            if (col) m_state = 2;
            else begin
               if (m_cyc % SCROLL == SCROLL - 1) begin
                  if (m_gap[14] >= 0 && m_score < 255) m_score++;
                  for (int c = 15; c > 0; c--) m_gap[c] = m_gap[c-1];
                  m_gap[0] = (m_ticks % SPACE == 0) ? gap_of(m_lfsr) : -1;
                  m_ticks++;
               end
               if (m_cyc % FALL == FALL - 1) begin
                  if (p) m_row = (m_row > 0) ? m_row - 1 : 0;
                  else   m_row = (m_row < 15) ? m_row + 1 : 15;
               end
               m_cyc++;
            end
         end
         default: if (rise) begin
            m_state = 0; m_row = 7;
            for (int c = 0; c < 16; c++) m_gap[c] = -1;
         end
      endcase
      m_press_prev = p;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   endtask

   task automatic compare_all();
      check("state", 256'(state), 256'(m_state));
      check("game_over", 256'(game_over), 256'(m_state == 2));
      check("red", red, onehot(m_row));
      check("green", green, exp_green());
      check("score", 256'(score), 256'(m_score));
   endtask

   task automatic cycle(input bit p, input bit col);
      press = p; collision = col;
      @(posedge clk);
      model_update(p, col);
      @(negedge clk);
      compare_all();
   endtask

   // Reset is asserted between edges and checked before the next rising edge.
   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b0; press = 1'b0; collision = 1'b0;
      model_reset();
      #1;
      check("rst_state", 256'(state), 256'(0));
      check("rst_red", red, onehot(7));
      check("rst_green", green, 256'(0));
      check("rst_score", 256'(score), 256'(0));
      check("rst_game_over", 256'(game_over), 256'(0));
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic [255:0] saved_green;
   logic [7:0]   saved_score;

   initial begin
      rst = 1'b0; press = 1'b0; collision = 1'b0;
      model_reset();
      do_reset();

      for (int i = 0; i < 20; i++) cycle(0, 0);

      cycle(1, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0);
      check("play_entered", 256'(state), 256'(1));
      check("bird_row_11", red, onehot(11));

      for (int i = 0; i < 30; i++) cycle(1, 0);
      check("bird_top_sat", red, onehot(0));

      for (int i = 0; i < 120; i++) cycle(1'($urandom_range(0, 1)), 0);
      check("score_after_run", 256'(score), 256'(4));

      for (int i = 0; i < 8 && (m_cyc % SCROLL) != SCROLL - 1; i++)
         cycle(1'($urandom_range(0, 1)), 0);
      saved_green = green;
      saved_score = score;
      cycle(0, 1);
      check("over_state", 256'(state), 256'(2));
      check("over_flag", 256'(game_over), 256'(1));
      check("over_green_hold", green, saved_green);
      check("over_score_hold", 256'(score), 256'(saved_score));
      for (int i = 0; i < 12; i++) cycle(0, 1'($urandom_range(0, 1)));
      check("over_green_frozen", green, saved_green);

      cycle(1, 0);
      check("idle_state", 256'(state), 256'(0));
      check("idle_green", green, 256'(0));
      check("idle_bird", red, onehot(7));
      check("idle_score_kept", 256'(score), 256'(saved_score));
      cycle(0, 0);
      cycle(1, 0);
      check("replay_state", 256'(state), 256'(1));
      check("replay_score", 256'(score), 256'(0));

      for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), 0);
      do_reset();

      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
